// File: rtl/tlv5638_dac_drv_pkg.sv
// Shared definitions for the TLV5638 dual-DAC driver: frame field
// constants, state encodings and the data-frame builder.
package tlv5638_dac_drv_pkg;

    // R1R0 register-select codes (R1 sits at bit 15, R0 at bit 12)
    localparam logic [1:0] R_BUF   = 2'b01;
    localparam logic [1:0] R_A_UPD = 2'b10;
    localparam logic [1:0] R_CTRL  = 2'b11;

    // Speed-select bit, always set for fast settling
    localparam int unsigned SPD_BIT = 14;

    // Control register: R=11, fast, powered, internal 2.048 V reference
    localparam logic [15:0] CTRL_WORD_DEF = 16'hD002;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_CTRL,
        ST_GAP_C,
        ST_IDLE,
        ST_SEND_B,
        ST_GAP_B,
        ST_SEND_A,
        ST_GAP_A
    } drv_state_t;

    typedef enum logic [2:0] {
        SH_IDLE,
        SH_LEAD,
        SH_HIGH,
        SH_LOW,
        SH_TAIL
    } shift_state_t;

    // Build a 16-bit DAC frame from a register select and an 8-bit sample
    // (sample occupies the top of the 12-bit code, low nibble zero)
    function automatic logic [15:0] mk_frame(input logic [1:0] r, input logic [7:0] code);
        logic [15:0] f;
        f = {r[1], 1'b0, 1'b0, r[0], code, 4'h0};
        f[SPD_BIT] = 1'b1;
        return f;
    endfunction

endpackage

// File: rtl/tlv5638_dac_drv_if.sv
// Sample input and DAC pin bundle for the TLV5638 driver.
interface tlv5638_dac_drv_if;
    logic [15:0] data_i;
    logic        valid_i;
    logic        dac_cs_n;
    logic        dac_sclk;
    logic        dac_din;
    logic        busy;
    logic        upd_o;

    // Upstream side: supplies samples, observes the DAC pins and status
    modport master (
        output data_i, valid_i,
        input  dac_cs_n, dac_sclk, dac_din, busy, upd_o
    );

    // Driver side
    modport slave (
        input  data_i, valid_i,
        output dac_cs_n, dac_sclk, dac_din, busy, upd_o
    );
endinterface

// File: rtl/tlv5638_dac_drv_spi_shift.sv
// One-word 3-wire serialiser: on i_start, frames i_word MSB first with
// FS low, SCLK idling high and DIN changing only on SCLK rising edges.
// o_done is high during the last FS-low cycle.
module dac_spi_shift
    import tlv5638_dac_drv_pkg::*;
#(
    parameter int unsigned HALF_DIV = 2
) (
    input  logic        clk_16M,
    input  logic        rst,
    input  logic        i_start,
    input  logic [15:0] i_word,
    output logic        o_cs_n,
    output logic        o_sclk,
    output logic        o_din,
    output logic        o_done
);

    localparam logic [7:0] HALF_LAST = 8'(HALF_DIV - 1);

    shift_state_t r_state;
    logic [15:0]  r_shreg;
    logic [3:0]   r_bit;
    logic [7:0]   r_half;

    // Frame sequencer: lead cycle, 16 x (high, low) bit phases, tail cycle
    always_ff @(posedge clk_16M or negedge rst) begin
        if (!rst) begin
            r_state <= SH_IDLE;
            r_shreg <= '0;
            r_bit   <= '0;
            r_half  <= '0;
            o_cs_n  <= 1'b1;
            o_sclk  <= 1'b1;
            o_din   <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (r_state)
                SH_IDLE: begin
                    if (i_start) begin
                        r_shreg <= i_word;
                        r_bit   <= 4'd15;
                        r_half  <= '0;
                        o_cs_n  <= 1'b0;
                        o_sclk  <= 1'b1;
                        o_din   <= i_word[15];
                        r_state <= SH_LEAD;
                    end
                end
                SH_LEAD: begin
                    r_half  <= '0;
                    r_state <= SH_HIGH;
                end
                SH_HIGH: begin
                    if (r_half == HALF_LAST) begin
                        r_half  <= '0;
                        o_sclk  <= 1'b0;
                        r_state <= SH_LOW;
                    end else begin
                        r_half <= r_half + 8'd1;
                    end
                end
                SH_LOW: begin
                    if (r_half == HALF_LAST) begin
                        r_half <= '0;
                        o_sclk <= 1'b1;
                        if (r_bit == 4'd0) begin
                            o_done  <= 1'b1;
                            r_state <= SH_TAIL;
                        end else begin
                            r_bit   <= r_bit - 4'd1;
                            o_din   <= r_shreg[14];
                            r_shreg <= {r_shreg[14:0], 1'b0};
                            r_state <= SH_HIGH;
                        end
                    end else begin
                        r_half <= r_half + 8'd1;
                    end
                end
                SH_TAIL: begin
                    o_cs_n  <= 1'b1;
                    o_din   <= 1'b0;
                    r_state <= SH_IDLE;
                end
                default: r_state <= SH_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/tlv5638_dac_drv.sv
// TLV5638 driver top: power-up control write, then one B-buffer write and
// one A-with-update write per received sample, with a one-deep
// latest-wins pending buffer for samples arriving while busy.
module tlv5638_dac_drv
    import tlv5638_dac_drv_pkg::*;
#(
    parameter int unsigned HALF_DIV  = 2,
    parameter int unsigned INIT_WAIT = 1600,
    parameter logic [15:0] CTRL_WORD = CTRL_WORD_DEF,
    parameter int unsigned GAP_CYC   = 4
) (
    input  logic              clk_16M,
    input  logic              rst,
    tlv5638_dac_drv_if.slave  bus
);

    localparam logic [15:0] INIT_LAST = 16'(INIT_WAIT - 1);
    localparam logic [15:0] GAP_LAST  = 16'(GAP_CYC - 1);

    drv_state_t  r_state;
    logic [15:0] r_cnt;
    logic [15:0] r_cur;
    logic [15:0] r_pend;
    logic        r_pend_v;
    logic        r_start;
    logic        r_busy;
    logic        r_upd;

    logic [15:0] w_word;
    logic        w_cs_n;
    logic        w_sclk;
    logic        w_din;
    logic        w_done;

    // Frame offered to the serialiser; r_start is registered together with
    // the state change, so the word is already selected when it is sampled
    always_comb begin
        w_word = CTRL_WORD;
        case (r_state)
            ST_SEND_B: w_word = mk_frame(R_BUF,   r_cur[15:8]);
            ST_SEND_A: w_word = mk_frame(R_A_UPD, r_cur[7:0]);
            default:   w_word = CTRL_WORD;
        endcase
    end

    // Sequencing FSM plus pending-sample capture
    always_ff @(posedge clk_16M or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_INIT;
            r_cnt    <= '0;
            r_cur    <= '0;
            r_pend   <= '0;
            r_pend_v <= 1'b0;
            r_start  <= 1'b0;
            r_busy   <= 1'b1;
            r_upd    <= 1'b0;
        end else begin
            r_start <= 1'b0;
            r_upd   <= 1'b0;
            if (bus.valid_i && (r_state != ST_IDLE)) begin
                r_pend   <= bus.data_i;
                r_pend_v <= 1'b1;
            end
            case (r_state)
                ST_INIT: begin
                    if (r_cnt == INIT_LAST) begin
                        r_cnt   <= '0;
                        r_start <= 1'b1;
                        r_state <= ST_CTRL;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                ST_CTRL: begin
                    if (w_done) begin
                        r_cnt   <= '0;
                        r_state <= ST_GAP_C;
                    end
                end
                ST_GAP_C: begin
                    if (r_cnt == GAP_LAST) begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                ST_IDLE: begin
                    // A fresh strobe outranks (and discards) an older pending word
                    if (bus.valid_i) begin
                        r_cur    <= bus.data_i;
                        r_pend_v <= 1'b0;
                        r_start  <= 1'b1;
                        r_busy   <= 1'b1;
                        r_state  <= ST_SEND_B;
                    end else if (r_pend_v) begin
                        r_cur    <= r_pend;
                        r_pend_v <= 1'b0;
                        r_start  <= 1'b1;
                        r_busy   <= 1'b1;
                        r_state  <= ST_SEND_B;
                    end
                end
                ST_SEND_B: begin
                    if (w_done) begin
                        r_cnt   <= '0;
                        r_state <= ST_GAP_B;
                    end
                end
                ST_GAP_B: begin
                    if (r_cnt == GAP_LAST) begin
                        r_cnt   <= '0;
                        r_start <= 1'b1;
                        r_state <= ST_SEND_A;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                ST_SEND_A: begin
                    if (w_done) begin
                        r_cnt   <= '0;
                        r_upd   <= 1'b1;
                        r_state <= ST_GAP_A;
                    end
                end
                ST_GAP_A: begin
                    if (r_cnt == GAP_LAST) begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

    dac_spi_shift #(
        .HALF_DIV (HALF_DIV)
    ) u_shift (
        .clk_16M (clk_16M),
        .rst     (rst),
        .i_start (r_start),
        .i_word  (w_word),
        .o_cs_n  (w_cs_n),
        .o_sclk  (w_sclk),
        .o_din   (w_din),
        .o_done  (w_done)
    );

    assign bus.dac_cs_n = w_cs_n;
    assign bus.dac_sclk = w_sclk;
    assign bus.dac_din  = w_din;
    assign bus.busy     = r_busy;
    assign bus.upd_o    = r_upd;

endmodule

// File: doc/tlv5638_dac_drv.md
Name: tlv5638_dac_drv

Overview:
- Downstream consumer of the 32K serial receiver. Takes each 16-bit word {chanB[7:0], chanA[7:0]} plus its one-cycle done strobe.
- Drives both channels of a TLV5638 dual 12-bit serial DAC over its 3-wire interface (FS/SCLK/DIN).
- After reset, writes the DAC control register once. Then, for each received word, writes channel B to the DAC buffer and channel A with simultaneous update, so both outputs change together.

Parameters:
- HALF_DIV, 2, clk_16M cycles per SCLK half-period (SCLK = 16M/(2*HALF_DIV) = 4 MHz); legal 1..255.
- INIT_WAIT, 1600, clk_16M cycles after reset before the control write (100 us DAC power-up).
- CTRL_WORD, 16'hD002, control register frame: R1R0=11, SPD=1 fast, PWR=0, REF=10 internal 2.048 V.
- GAP_CYC, 4, minimum cs_n-high cycles between frames.

Ports:
- clk_16M  in  1  system clock, 16 MHz
- rst  in  1  asynchronous, active-low reset
- data_i  in  16  sample word; [7:0]=channel A, [15:8]=channel B
- valid_i  in  1  one-cycle strobe, data_i valid (receiver done)
- dac_cs_n  out  1  TLV5638 FS, active low, frames one 16-bit word
- dac_sclk  out  1  serial clock, idles high
- dac_din  out  1  serial data, MSB first
- busy  out  1  high from the INIT state until the end of the current A frame's gap
- upd_o  out  1  one-cycle pulse when the channel-A frame (DAC update) completes

Behaviour:
- Reset values: dac_cs_n=1, dac_sclk=1, dac_din=0, busy=1, upd_o=0, pending flag=0. FSM enters INIT.
- Frame construction from data_i (latched on valid_i):
  - codeA = {A[7:0],4'h0}; codeB = {B[7:0],4'h0}.
  - Word B = 16'h5000 | codeB (R1R0=01, write buffer, SPD=1).
  - Word A = 16'hC000 | codeA (R1R0=10, write A and update B from buffer, SPD=1).
- Frame timing, one frame = 1 + 32*HALF_DIV + 1 cycles:
  - Cycle 0: cs_n falls, sclk=1, din = bit15.
  - Each bit: sclk high for HALF_DIV cycles, then low for HALF_DIV cycles. The DAC samples din on the falling edge.
  - din changes only on cycles where sclk rises, or at frame start. It is stable for at least one full clk_16M cycle around each falling edge.
  - After bit0's low phase, sclk returns high. cs_n rises one cycle later.
  - Then cs_n stays high for GAP_CYC cycles before the next frame may begin.
- FSM states:
  - INIT: count INIT_WAIT cycles -> CTRL.
  - CTRL: shift CTRL_WORD -> GAP -> IDLE.
  - IDLE: busy=0. When valid_i or the pending flag is set -> SEND_B.
  - SEND_B: shift word B -> GAP_B.
  - GAP_B -> SEND_A.
  - SEND_A: shift word A -> GAP_A; upd_o pulses on the cycle cs_n rises.
  - GAP_A -> IDLE.
- Sample buffering: one-deep pending register.
  - valid_i while busy stores data_i and sets pending.
  - A later valid_i before service overwrites the stored word (latest wins).
  - The active pair always transmits the word latched at SEND_B entry. A and B of one pair are never mixed across words.
  - valid_i in the same cycle IDLE exits: that word is used directly and pending stays 0.
  - valid_i during INIT/CTRL is kept in pending and served after CTRL.
- Shift counter is 4 bits (15 down to 0). The half-period counter is 8 bits and wraps to 0 on reaching HALF_DIV-1.
- Asynchronous reset mid-frame: cs_n goes high and sclk high immediately. The partial frame is discarded by the DAC. The control word is rewritten after INIT_WAIT.

Decomposition:
- Shared package (dac_pkg): R-field constants (R_BUF=2'b01, R_A_UPD=2'b10, R_CTRL=2'b11), SPD bit position, CTRL_WORD default, state encoding localparams.
- Sub-module dac_spi_shift (load 16-bit word + start strobe -> cs_n/sclk/din + done pulse). The top holds only the FSM and the pending buffer.

Test Plan:
- Reset release: outputs 1/1/0, busy=1. After INIT_WAIT=1600 cycles, one frame decoded on sclk falling edges = 16'hD002. Then busy=0.
- valid_i with data_i=16'hB45A in IDLE: frames 16'h5B40 then 16'hC5A0. Each frame is 66 cycles with cs_n low. Gap ≥4 cycles. upd_o is a one-cycle pulse after the second frame.
- Timing check at HALF_DIV=2: sclk period is 4 cycles. din never toggles within one cycle either side of a falling edge. Exactly 16 falling edges per cs_n-low window.
- valid_i 16'h1122, then 16'h3344 and 16'h5566 while busy: frames 5110/C220, then 5550/C660. 16'h3344 is never sent.
- valid_i 16'hFF00 during INIT: after D002, frames 5FF0 and C000 follow.
- Reset asserted at bit 7 of a data frame: cs_n=1 and sclk=1 in the same cycle. After release, D002 is resent and no stale pending frame is sent.
